// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 scan-code decoder: pops receiver FIFO, resolves E0/F0, emits key events.
// Optional ASCII table enabled by defining PS2_KEY_DECODER_ASCII_EN.
module ps2_key_decoder #(
  parameter int          COUNT_W = 8,
  parameter logic [7:0]  SHIFT_L = 8'h12,
  parameter logic [7:0]  SHIFT_R = 8'h59
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [7:0]         i_ps2_data,
  input  logic               i_ps2_ready,
  output logic               o_nextdata_n,
  output logic               o_key_valid,
  output logic [7:0]         o_key_code,
  output logic               o_key_ext,
  output logic               o_key_break,
  output logic               o_key_repeat,
  output logic               o_key_pressed,
  output logic [7:0]         o_key_ascii,
  output logic [COUNT_W-1:0] o_key_count
);

  typedef enum logic [1:0] {S_IDLE, S_POP, S_PROC} state_t;

  state_t             state_q, state_d;
  logic [7:0]         byte_q, byte_d;
  logic               nextdata_q, nextdata_d;
  logic               valid_q, valid_d;
  logic [7:0]         code_q, code_d;
  logic               ext_q, ext_d;
  logic               brk_q, brk_d;
  logic               rep_q, rep_d;
  logic               pressed_q, pressed_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               ext_pend_q, ext_pend_d;
  logic               brk_pend_q, brk_pend_d;
  logic [7:0]         held_code_q, held_code_d;
  logic               held_ext_q, held_ext_d;
  logic               shift_q, shift_d;
  logic               is_mod, held_match;

  assign is_mod     = !ext_pend_q && (byte_q == SHIFT_L || byte_q == SHIFT_R);
  assign held_match = ({ext_pend_q, byte_q} == {held_ext_q, held_code_q});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      byte_q      <= 8'h00;
      nextdata_q  <= 1'b1;
      valid_q     <= 1'b0;
      code_q      <= 8'h00;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      rep_q       <= 1'b0;
      pressed_q   <= 1'b0;
      count_q     <= '0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      held_code_q <= 8'h00;
      held_ext_q  <= 1'b0;
      shift_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      nextdata_q  <= nextdata_d;
      valid_q     <= valid_d;
      code_q      <= code_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      rep_q       <= rep_d;
      pressed_q   <= pressed_d;
      count_q     <= count_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      held_code_q <= held_code_d;
      held_ext_q  <= held_ext_d;
      shift_q     <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_ps2_ready) state_d = S_POP;
      S_POP:   state_d = S_PROC;
      S_PROC:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef PS2_KEY_DECODER_ASCII_EN
  logic [7:0] ascii_q, ascii_d;

  function automatic logic [7:0] ascii_of(input logic [7:0] c, input logic up);
    logic [7:0] a;
    a = 8'h00;
    case (c)
      8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
      8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
      8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
      8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
      8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h29: a = 8'h20;
      8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
    if (up && a >= 8'h61 && a <= 8'h7A) a = a - 8'h20;
    return a;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) ascii_q <= 8'h00;
    else       ascii_q <= ascii_d;
  end

  always_comb begin
    ascii_d = ascii_q;
    if (state_q == S_PROC && byte_q != 8'hE0 && byte_q != 8'hF0)
      ascii_d = (ext_pend_q || is_mod) ? 8'h00 : ascii_of(byte_q, shift_q);
  end

  assign o_key_ascii = ascii_q;
`else
  assign o_key_ascii = 8'h00;
`endif

  always_comb begin
    byte_d      = byte_q;
    nextdata_d  = nextdata_q;
    valid_d     = 1'b0;
    code_d      = code_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    rep_d       = rep_q;
    pressed_d   = pressed_q;
    count_d     = count_q;
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    held_code_d = held_code_q;
    held_ext_d  = held_ext_q;
    shift_d     = shift_q;
    case (state_q)
      S_IDLE: begin
        if (i_ps2_ready) begin
          byte_d     = i_ps2_data;
          nextdata_d = 1'b0;
        end
      end
      S_POP: nextdata_d = 1'b1;
      S_PROC: begin
        if (byte_q == 8'hE0) begin
          ext_pend_d = 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk_pend_d = 1'b1;
        end else begin
          valid_d    = 1'b1;
          code_d     = byte_q;
          ext_d      = ext_pend_q;
          brk_d      = brk_pend_q;
          rep_d      = 1'b0;
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
          if (is_mod) begin
            shift_d = !brk_pend_q;
          end else if (!brk_pend_q) begin
            // Typematic repeat of the held key must not bump the press counter.
            if (pressed_q && held_match) begin
              rep_d = 1'b1;
            end else begin
              held_code_d = byte_q;
              held_ext_d  = ext_pend_q;
              pressed_d   = 1'b1;
              count_d     = count_q + COUNT_W'(1);
            end
          end else if (held_match) begin
            pressed_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  assign o_nextdata_n  = nextdata_q;
  assign o_key_valid   = valid_q;
  assign o_key_code    = code_q;
  assign o_key_ext     = ext_q;
  assign o_key_break   = brk_q;
  assign o_key_repeat  = rep_q;
  assign o_key_pressed = pressed_q;
  assign o_key_count   = count_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed bench for ps2_key_decoder with a receiver FIFO model.
module tb_ps2_key_decoder;

`ifdef PS2_KEY_DECODER_ASCII_EN
  localparam bit AEN = 1'b1;
`else
  localparam bit AEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ps2_data;
  logic       ps2_ready;
  logic       nextdata_n, key_valid, key_ext, key_break, key_repeat, key_pressed;
  logic [7:0] key_code, key_ascii, key_count;

  always #5 clk = ~clk;

  logic [7:0] fifo_mem [0:2047];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign ps2_ready = (wr_ptr != rd_ptr);
  assign ps2_data  = fifo_mem[rd_ptr[10:0]];

  ps2_key_decoder dut (
    .i_clk(clk), .i_rst(rst), .i_ps2_data(ps2_data), .i_ps2_ready(ps2_ready),
    .o_nextdata_n(nextdata_n), .o_key_valid(key_valid), .o_key_code(key_code),
    .o_key_ext(key_ext), .o_key_break(key_break), .o_key_repeat(key_repeat),
    .o_key_pressed(key_pressed), .o_key_ascii(key_ascii), .o_key_count(key_count)
  );

  always @(posedge clk) if (!nextdata_n && ps2_ready) rd_ptr <= rd_ptr + 1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ev_code [0:1023];
  logic       ev_ext [0:1023], ev_brk [0:1023], ev_rep [0:1023], ev_prs [0:1023];
  logic [7:0] ev_cnt_v [0:1023], ev_asc [0:1023];
  int ev_cyc [0:1023];
  int ev_n = 0, pop_n = 0, last_pop_cyc = 0, dbl_valid = 0, dbl_pop = 0;
  logic valid_prev = 1'b0, pop_prev = 1'b0;

  always @(negedge clk) begin
    valid_prev <= key_valid;
    pop_prev   <= !nextdata_n;
    if (key_valid && valid_prev) dbl_valid <= dbl_valid + 1;
    if (!nextdata_n && pop_prev) dbl_pop <= dbl_pop + 1;
    if (!nextdata_n) begin
      pop_n        <= pop_n + 1;
      last_pop_cyc <= cyc;
    end
    if (key_valid && ev_n < 1024) begin
      ev_code[ev_n]  <= key_code;
      ev_ext[ev_n]   <= key_ext;
      ev_brk[ev_n]   <= key_break;
      ev_rep[ev_n]   <= key_repeat;
      ev_prs[ev_n]   <= key_pressed;
      ev_cnt_v[ev_n] <= key_count;
      ev_asc[ev_n]   <= key_ascii;
      ev_cyc[ev_n]   <= cyc;
      ev_n           <= ev_n + 1;
    end
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ea(input logic [7:0] a);
    return AEN ? a : 8'h00;
  endfunction

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr[10:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (wr_ptr != rd_ptr && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (wr_ptr != rd_ptr) check("drain_timeout", 1, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_ev(input string tag, input int i, input logic [7:0] code, input logic ext,
                        input logic brk, input logic rep, input logic prs, input logic [7:0] cnt,
                        input logic [7:0] asc);
    check({tag, ".code"},  ev_code[i],  code);
    check({tag, ".ext"},   ev_ext[i],   ext);
    check({tag, ".brk"},   ev_brk[i],   brk);
    check({tag, ".rep"},   ev_rep[i],   rep);
    check({tag, ".prs"},   ev_prs[i],   prs);
    check({tag, ".cnt"},   ev_cnt_v[i], cnt);
    check({tag, ".ascii"}, ev_asc[i],   asc);
  endtask

  initial begin
    int e0, p0;
    logic [7:0] t2 [5]  = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    logic [7:0] t3 [7]  = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
    logic [7:0] t4 [5]  = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    logic [7:0] t5 [6]  = '{8'h1C, 8'h32, 8'hF0, 8'h1C, 8'hF0, 8'h32};
    logic [7:0] k;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst.nextdata_n", nextdata_n, 1);
    check("rst.valid", key_valid, 0);
    check("rst.code", key_code, 0);
    check("rst.pressed", key_pressed, 0);
    check("rst.count", key_count, 0);
    check("rst.ascii", key_ascii, 0);

    // single make
    e0 = ev_n; p0 = pop_n;
    push(8'h1C);
    wait_idle();
    check("t1.events", ev_n - e0, 1);
    check("t1.pops", pop_n - p0, 1);
    check("t1.latency", ev_cyc[e0] - last_pop_cyc, 2);
    chk_ev("t1", e0, 8'h1C, 0, 0, 0, 1, 1, ea(8'h61));

    // typematic repeats then release
    e0 = ev_n; p0 = pop_n;
    foreach (t2[i]) push(t2[i]);
    wait_idle();
    check("t2.events", ev_n - e0, 4);
    check("t2.pops", pop_n - p0, 5);
    for (int i = 0; i < 3; i++) chk_ev($sformatf("t2.rep%0d", i), e0 + i, 8'h1C, 0, 0, 1, 1, 1, ea(8'h61));
    chk_ev("t2.brk", e0 + 3, 8'h1C, 0, 1, 0, 0, 1, ea(8'h61));

    // shift modifier
    do_reset();
    e0 = ev_n;
    foreach (t3[i]) push(t3[i]);
    wait_idle();
    check("t3.events", ev_n - e0, 5);
    chk_ev("t3.shmk", e0,     8'h12, 0, 0, 0, 0, 0, 8'h00);
    chk_ev("t3.A",    e0 + 1, 8'h1C, 0, 0, 0, 1, 1, ea(8'h41));
    chk_ev("t3.Abrk", e0 + 2, 8'h1C, 0, 1, 0, 0, 1, ea(8'h41));
    chk_ev("t3.shbk", e0 + 3, 8'h12, 0, 1, 0, 0, 1, 8'h00);
    chk_ev("t3.a",    e0 + 4, 8'h1C, 0, 0, 0, 1, 2, ea(8'h61));

    // extended make/break
    do_reset();
    e0 = ev_n;
    foreach (t4[i]) push(t4[i]);
    wait_idle();
    check("t4.events", ev_n - e0, 2);
    chk_ev("t4.mk", e0,     8'h75, 1, 0, 0, 1, 1, 8'h00);
    chk_ev("t4.bk", e0 + 1, 8'h75, 1, 1, 0, 0, 1, 8'h00);

    // rollover and non-matching break
    do_reset();
    e0 = ev_n;
    foreach (t5[i]) push(t5[i]);
    wait_idle();
    check("t5.events", ev_n - e0, 4);
    chk_ev("t5.mk1", e0,     8'h1C, 0, 0, 0, 1, 1, ea(8'h61));
    chk_ev("t5.mk2", e0 + 1, 8'h32, 0, 0, 0, 1, 2, ea(8'h62));
    chk_ev("t5.nmb", e0 + 2, 8'h1C, 0, 1, 0, 1, 2, ea(8'h61));
    chk_ev("t5.bk2", e0 + 3, 8'h32, 0, 1, 0, 0, 2, ea(8'h62));

    // counter wrap
    do_reset();
    e0 = ev_n;
    for (int i = 0; i < 255; i++) begin
      k = (i % 2 == 0) ? 8'h1C : 8'h32;
      push(k); push(8'hF0); push(k);
      if (i % 32 == 31) wait_idle();
    end
    wait_idle();
    check("t6.count255", key_count, 8'd255);
    push(8'h32); push(8'hF0); push(8'h32);
    wait_idle();
    check("t6.events", ev_n - e0, 512);
    check("t6.wrap_make", ev_cnt_v[ev_n - 2], 8'd0);
    check("t6.count0", key_count, 8'd0);

    // reset discards pending break
    do_reset();
    e0 = ev_n;
    push(8'hF0);
    wait_idle();
    rst = 1'b1;
    @(negedge clk);
    check("t7.rst_nextdata_n", nextdata_n, 1);
    check("t7.rst_valid", key_valid, 0);
    rst = 1'b0;
    push(8'h1C);
    wait_idle();
    check("t7.events", ev_n - e0, 1);
    chk_ev("t7.mk", e0, 8'h1C, 0, 0, 0, 1, 1, ea(8'h61));

    check("valid_width", dbl_valid, 0);
    check("pop_width", dbl_pop, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
